// File: rtl/div_unit_pkg.sv
// Shared defines for the EX-stage divider: decoder op codes, FSM state encodings and iteration count.
package div_unit_pkg;

  localparam int DIV_ITERS = 32;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration on the {remainder, quotient} register.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0]   i_divisor,
  output logic [2*DATA_W-1:0] o_acc
);

  logic [2*DATA_W-1:0] w_shift;
  logic [DATA_W+1:0]   w_diff;

  always_comb begin
    w_shift = {i_acc[2*DATA_W-2:0], 1'b0};
    // The trial uses the bit shifted out of the top so divisors above 2^(W-1) work.
    w_diff  = {1'b0, i_acc[2*DATA_W-1:DATA_W-1]} - {2'b00, i_divisor};
    if (!w_diff[DATA_W+1]) begin
      o_acc = {w_diff[DATA_W-1:0], w_shift[DATA_W-1:1], 1'b1};
    end else begin
      o_acc = {w_shift[2*DATA_W-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage; zero-divisor short cut enabled by DIV_ZERO_CHECK_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  output logic              stall,
  output logic              valid,
  output logic [DATA_W-1:0] lo_result,
`ifdef DIV_ZERO_CHECK_EN
  output logic [DATA_W-1:0] hi_result,
  output logic              div_zero
`else
  output logic [DATA_W-1:0] hi_result
`endif
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_signed;
  logic                r_sign1;
  logic                r_sign2;
  logic [DATA_W-1:0]   r_divisor;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_fix_lo;
  logic [DATA_W-1:0]   r_fix_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_hi;
`ifdef DIV_ZERO_CHECK_EN
  logic                r_dz;
  logic                w_dz_now;
`endif

  logic [2*DATA_W-1:0] w_step;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic                w_done_ok;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .i_acc     (r_acc),
    .i_divisor (r_divisor),
    .o_acc     (w_step)
  );

  always_comb begin
    w_abs1 = cond_neg(num1, signed_div & num1[DATA_W-1]);
    w_abs2 = cond_neg(num2, signed_div & num2[DATA_W-1]);
`ifdef DIV_ZERO_CHECK_EN
    w_dz_now = (num2 == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start && !annul) begin
            r_signed  <= signed_div;
            r_sign1   <= num1[DATA_W-1];
            r_sign2   <= num2[DATA_W-1];
            r_divisor <= w_abs2;
            r_acc     <= {{DATA_W{1'b0}}, w_abs1};
            r_cnt     <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (w_dz_now) begin
              r_fix_lo <= '1;
              r_fix_hi <= num1;
              r_dz     <= 1'b1;
              r_state  <= DIV_DONE;
            end else begin
              r_dz     <= 1'b0;
              r_state  <= DIV_BUSY;
            end
`else
            r_state   <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          if (annul) begin
            r_state <= DIV_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
            // Sign fix-up is folded into the final step so DONE only presents it.
            if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
              r_fix_lo <= cond_neg(w_step[DATA_W-1:0], r_signed & (r_sign1 ^ r_sign2));
              r_fix_hi <= cond_neg(w_step[2*DATA_W-1:DATA_W], r_signed & r_sign1);
              r_state  <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          if (!annul) begin
            r_lo <= r_fix_lo;
            r_hi <= r_fix_hi;
          end
          r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  // An annul in DONE suppresses the pulse and keeps the previously held result visible.
  always_comb begin
    w_done_ok = (r_state == DIV_DONE) & ~annul;
    valid     = w_done_ok;
    lo_result = w_done_ok ? r_fix_lo : r_lo;
    hi_result = w_done_ok ? r_fix_hi : r_hi;
    stall     = ((r_state == DIV_IDLE) & start & ~annul) | (r_state == DIV_BUSY);
`ifdef DIV_ZERO_CHECK_EN
    div_zero  = w_done_ok & r_dz;
`endif
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the MIPS EX stage, executing DIV and DIVU beside the combinational `alu`. It takes the same two source operands, runs a radix-2 restoring division over 32 iteration cycles, and delivers quotient and remainder for the HI/LO write path. While it works it stalls the pipeline. `alu` keeps all single-cycle operations.

## Interface
- `DATA_W`, default 32: operand width. Only 32 is supported; the parameter is for readability.
- `clk` in 1: clock, all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: request a division. Sampled only in IDLE.
- `signed_div` in 1: 1 selects DIV, 0 selects DIVU. Latched with `start`.
- `annul` in 1: abort the current operation (exception or flush).
- `num1` in 32: dividend (rs). Latched with `start`.
- `num2` in 32: divisor (rt). Latched with `start`.
- `stall` out 1: hold the pipeline.
- `valid` out 1: one-cycle pulse marking a completed result.
- `lo_result` out 32: quotient.
- `hi_result` out 32: remainder.
- `div_zero` out 1: divisor was zero. Present only with `DIV_ZERO_CHECK_EN`.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE with `start`=1:**
  - Latch `signed_div`, sign of `num1`, sign of `num2`, |num1| and |num2|. Magnitudes apply only when signed; otherwise the raw values are used.
  - Clear the 64-bit partial-remainder/quotient register with the dividend in its low half.
  - Set the iteration counter to 0 and go to BUSY.
- **BUSY:** one restoring step per cycle.
  - Shift the register left 1.
  - Form the trial difference: upper 33 bits minus {1'b0, divisor}.
  - If non-negative, commit it and set quotient bit 1; otherwise keep the shifted value and set bit 0.
  - Increment the counter. After the counter reaches 31, go to DONE.
- **DONE:**
  - Sign fix-up: quotient is negated when signed and operand signs differ. Remainder is negated when signed and the dividend is negative.
  - Register the fixed-up values into `lo_result`/`hi_result`, assert `valid` for this cycle and go to IDLE.
- **Overflow case:** signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 by two's-complement wrap. No trap is raised.
- **`annul`:** in BUSY or DONE, return to IDLE on the next edge. No `valid` pulse, and `hi_result`/`lo_result` are unchanged. `annul` in IDLE has no effect.
- **`start` outside IDLE:** ignored.
- **`start` and `annul` together in IDLE:** `annul` wins and the operation does not begin.
- **Outputs between operations:** `hi_result`/`lo_result` hold the last completed result until the next completion.
- **Reset:**
  - Values: state IDLE, counter 0, `valid` 0, `hi_result`/`lo_result` 0, `div_zero` 0.
  - Reset mid-operation discards the operation.

## Timing
- `stall` is combinational: (IDLE & `start` & ~`annul`) | BUSY.
- `stall` is low in the DONE cycle, so the instruction advances with `valid` high.
- Latency:
  - `start` sampled at edge N.
  - BUSY spans edges N+1…N+32.
  - DONE is the cycle after edge N+32, and `valid` is high in that cycle.
  - A new `start` is accepted at edge N+34 at the earliest.
- Operands must be stable only in the `start` cycle.

## Configuration
- **With `DIV_ZERO_CHECK_EN` defined:**
  - A zero divisor at `start` skips BUSY and goes directly to DONE, so `valid` comes one cycle after `start`.
  - Results: `lo_result`=0xFFFFFFFF, `hi_result`=`num1` raw, `div_zero`=1 with `valid`.
  - `div_zero` is 0 on every other completion.
- **Without it:**
  - No `div_zero` port.
  - A zero divisor takes the full 33-cycle path. The result is whatever the algorithm yields (architecturally UNPREDICTABLE).

## Structure
- The shared defines package carries:
  - `EXE_DIV_OP` and `EXE_DIVU_OP` alucontrol codes, used by the decoder to drive `start`/`signed_div`.
  - The 2-bit state encodings DIV_IDLE, DIV_BUSY, DIV_DONE.
  - `DIV_ITERS` = 32.
- One sub-module, `div_step`: a combinational single restoring iteration taking the 64-bit register and divisor and returning the next register value.

## Test plan
- **Unsigned:** DIVU 100 / 7 → `lo_result`=14, `hi_result`=2. `valid` 33 cycles after `start`, and `stall` high for exactly 33 cycles.
- **Signed:** DIV −7 / 2 → `lo_result`=0xFFFFFFFD, `hi_result`=0xFFFFFFFF. Also check DIV 7 / −2 → 0xFFFFFFFD, 1.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF → `lo_result`=0x80000000, `hi_result`=0, no trap. Also check DIVU of the same operands → `lo_result`=0, `hi_result`=0x80000000.
- **Annul:** `annul` in BUSY cycle 10 → no `valid`, `stall` low next cycle, outputs keep the prior result. An immediate new DIVU 9/3 → 3, 0.
- **Reset mid-operation:** `resetn`=0 during BUSY → next cycle IDLE, outputs 0. `start` while BUSY is ignored, with exactly one `valid` observed.
- **Zero divisor, with `DIV_ZERO_CHECK_EN`:** DIV 5 / 0 → `valid` one cycle after `start`, `lo_result`=0xFFFFFFFF, `hi_result`=5, `div_zero`=1. Without the macro, `valid` comes at 33 cycles.
